serial_addsub_seq: RTL and testbench



---
 rtl/serial_addsub_seq_pkg.sv | 16 +
 rtl/serial_addsub_seq_fa.sv | 17 +
 rtl/serial_addsub_seq.sv | 117 +++++++++++
 tb/tb_serial_addsub_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_seq_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_t : sequencer state encoding (2 bits)
//   cnt_w() : width of the bit-position counter for a given operand width
package serial_addsub_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_addsub_seq_fa.sv
// One-bit full adder slice shared by the serial sequencer.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module serial_addsub_seq_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit add/subtract, one bit per clock, LSB first.
//   clk, rst_n             : clock, async active-low reset
//   req_valid / req_ready  : request handshake (ready only in IDLE)
//   op_a, op_b, sub        : operands and op select, sampled on accept
//   resp_valid / resp_ready: response handshake (valid only in DONE)
//   result, carry_out      : registered sum/difference and MSB carry
//   overflow               : registered signed overflow
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_IDLE | waiting for a request, req_ready=1
// ST_RUN  | WIDTH edges, one result bit produced per edge
// ST_DONE | result held, resp_valid=1 until resp_ready
module serial_addsub_seq
    import serial_addsub_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s, fa_c;
    logic             last_bit;

    serial_addsub_seq_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign r_nxt    = {fa_s, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are captured on the final RUN edge so that they hold their
    // value outside DONE; carry at that edge is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_sr  <= op_a;
                        b_sr  <= op_b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sr  <= r_nxt;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        result    <= r_nxt;
                        carry_out <= fa_c;
                        overflow  <= carry ^ fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
module tb_serial_addsub_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       sub = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;

    int tests = 0;
    int failed = 0;

    serial_addsub_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .sub        (sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request and return at the negedge after the accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        op_a = a; op_b = b; sub = s; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count edges until resp_valid, noting whether req_ready was ever high.
    task automatic wait_resp(output int n, output logic rr_seen);
        n = 0; rr_seen = 1'b0;
        do begin
            if (req_ready) rr_seen = 1'b1;
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 30);
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("back_to_idle_valid", {31'd0, resp_valid}, 32'd0);
        check("back_to_idle_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] exp_r, input logic exp_c,
                          input logic exp_v);
        int   n;
        logic rr;
        start_op(a, b, s);
        wait_resp(n, rr);
        check({tag, "_latency"}, n, 8);
        check({tag, "_rdy_busy"}, {31'd0, rr}, 32'd0);
        check({tag, "_result"}, {24'd0, result}, {24'd0, exp_r});
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_c});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_v});
        consume();
    endtask

    initial begin
        int          n;
        logic        rr;
        int          cyc, ai, ri;
        int          acc_cyc[3];
        logic [7:0]  bb_a[3], bb_b[3], bb_r[3];
        logic        bb_s[3];

        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure, with operand and req_valid disturbances while busy.
        start_op(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op_a = 8'hFF - 8'(i);
            op_b = 8'h01;
            req_valid = ~req_valid;
            @(negedge clk);
        end
        req_valid = 1'b1;
        wait_resp(n, rr);
        check("bp_latency", n, 5);
        check("bp_rdy_busy", {31'd0, rr}, 32'd0);
        op_a = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
            check("bp_hold_result", {24'd0, result}, 32'h46);
            check("bp_hold_flags", {30'd0, carry_out, overflow}, 32'd0);
            req_valid = ~req_valid;
            @(negedge clk);
        end
        req_valid = 1'b0;
        consume();

        // Asynchronous reset between edges in the middle of RUN.
        start_op(8'hC3, 8'h11, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_result", {24'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Back-to-back with both valids held high.
        bb_a = '{8'h11, 8'hA0, 8'h03};
        bb_b = '{8'h22, 8'h30, 8'hFD};
        bb_s = '{1'b0, 1'b1, 1'b0};
        bb_r = '{8'h33, 8'h70, 8'h00};
        cyc = 0; ai = 0; ri = 0;
        resp_ready = 1'b1;
        while (ri < 3 && cyc < 60) begin
            if (resp_valid) begin
                check("b2b_result", {24'd0, result}, {24'd0, bb_r[ri]});
                ri++;
            end
            if (req_ready && ai < 3) begin
                op_a = bb_a[ai]; op_b = bb_b[ai]; sub = bb_s[ai];
                req_valid = 1'b1;
                acc_cyc[ai] = cyc;
                ai++;
            end else if (req_ready) begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        check("b2b_all_done", ri, 3);
        check("b2b_space_1", acc_cyc[1] - acc_cyc[0], 10);
        check("b2b_space_2", acc_cyc[2] - acc_cyc[1], 10);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
